mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Sequential signed multiply/divide unit on the datapath consumer side of the bus multiplexer.
- Operand A comes from the Y register; operand B comes directly from BusMuxOut.
- Produces a 64-bit result split into z_hi/z_lo, which the ZHI/ZLO registers capture. Those registers then drive the bus again.
- Replaces a single-cycle combinational MUL/DIV with a 32-iteration engine and a start/done handshake for the control sequencer.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  in  1  system clock; all state updates on rising edge.
clear  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
op  in  1  0 = MUL, 1 = DIV.
operand_a  in  WIDTH  multiplicand / dividend (Y register).
operand_b  in  WIDTH  multiplier / divisor (BusMuxOut).
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle completion pulse.
z_hi  out  WIDTH  MUL: product[63:32]; DIV: remainder.
z_lo  out  WIDTH  MUL: product[31:0]; DIV: quotient.
div_by_zero  out  1  set by a DIV with operand_b == 0; held until the next accepted start.

Behaviour:
- Reset: clear=1 at an edge forces state IDLE and counter=0. It also forces busy=0, done=0, z_hi=0, z_lo=0, div_by_zero=0. clear has priority over all other inputs.
- FSM states: IDLE, RUN, DZERO.
- IDLE:
  - start=1 at edge E0 latches op, operand_a and operand_b, and clears div_by_zero.
  - Next state is DZERO if op=1 and operand_b==0, else RUN with counter=0.
  - busy=1 from E0 onward.
- RUN:
  - One iteration per edge, E1..E32.
  - At E32, z_hi/z_lo are written, done=1, busy=0, and the state returns to IDLE.
  - done is cleared at E33. Latency from start edge to result edge is 32 cycles.
- DZERO:
  - At E1: z_hi=operand_a, z_lo=all ones, div_by_zero=1, done=1, busy=0, state returns to IDLE.
- MUL: radix-2 Booth over a 65-bit {acc, multiplier, q-1} register, arithmetic shift right each step. The result is the exact signed 64-bit product.
- DIV: restoring division on magnitudes, then sign correction.
  - Quotient is truncated toward zero.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives quotient 0x80000000 (wrap) and remainder 0; no flag is raised.
- start while busy=1 is ignored: no restart, no queueing, and operands are not re-sampled.
- start in the same cycle that done=1 is accepted, because the state is already IDLE.
- operand_b and operand_a may change freely after E0; only the latched copies are used.
- z_hi/z_lo/div_by_zero hold their values between operations. They change only at a completion edge or on clear.
- clear mid-RUN or mid-DZERO: IDLE at that edge, no done pulse, outputs zeroed.
- done and busy are never both 1.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MUL=0 and OP_DIV=1;
  - state encoding for IDLE/RUN/DZERO;
  - WIDTH default and the ITER=32 constant.
- Sub-module muldiv_iter: purely combinational single-step datapath.
  - Booth add/subtract/shift for MUL.
  - Trial-subtract/shift for DIV.
  - Instantiated once. The top level keeps the FSM, counter, operand latches and sign fix-up.

Test Plan:
- Reset: assert clear 2 cycles after arbitrary stimulus -> busy=0, done=0, z_hi=z_lo=0, div_by_zero=0.
- MUL 7 * -3: start at E0 -> done=1 exactly at E32; z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB; busy high for E0..E31 only.
- MUL -2^31 * -2^31 -> z_hi=0x40000000, z_lo=0x00000000. Then MUL 0x7FFFFFFF * 0x7FFFFFFF -> z_hi=0x3FFFFFFF, z_lo=0x00000001.
- DIV -7 / 2 -> z_lo=0xFFFFFFFD (-3), z_hi=0xFFFFFFFF (-1). Then DIV 0x80000000 / 0xFFFFFFFF -> z_lo=0x80000000, z_hi=0.
- DIV 100 / 0 -> done at E1, z_hi=100, z_lo=0xFFFFFFFF, div_by_zero=1. A following MUL 2*3 start clears the flag; result z_lo=6, z_hi=0.
- Handshake edge cases:
  - start pulsed at E10 of a running MUL with different operands -> ignored; the original result appears at E32.
  - clear at E15 -> IDLE, no done.
  - start in the done cycle -> accepted; the second done appears 32 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the sequential multiply/divide unit
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int ITER          = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DZERO = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one combinational step: Booth add/sub + arithmetic shift (MUL)
// or shift + trial subtract (DIV)
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_op,
    input  logic [WIDTH:0]   i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic             i_qm1,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH:0]   o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_qm1
);

    logic [WIDTH:0] w_acc;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Accumulator is one bit wider than the operand so subtracting -2^(W-1) cannot overflow.
    always_comb begin
        w_acc     = i_hi;
        w_shifted = {i_hi[WIDTH-1:0], i_lo[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, i_opnd};
        o_hi      = i_hi;
        o_lo      = i_lo;
        o_qm1     = 1'b0;
        if (i_op == OP_MUL) begin
            case ({i_lo[0], i_qm1})
                2'b01:   w_acc = i_hi + {i_opnd[WIDTH-1], i_opnd};
                2'b10:   w_acc = i_hi - {i_opnd[WIDTH-1], i_opnd};
                default: w_acc = i_hi;
            endcase
            o_hi  = {w_acc[WIDTH], w_acc[WIDTH:1]};
            o_lo  = {w_acc[0], i_lo[WIDTH-1:1]};
            o_qm1 = i_lo[0];
        end else if (!w_trial[WIDTH]) begin
            o_hi = w_trial;
            o_lo = {i_lo[WIDTH-2:0], 1'b1};
        end else begin
            o_hi = w_shifted;
            o_lo = {i_lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - sequential signed MUL/DIV with start/done handshake,
// one result bit per clock over WIDTH iterations
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             div_by_zero
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_qm1;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_z_hi;
    logic [WIDTH-1:0] r_z_lo;

    logic             w_last;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic             w_qm1_nx;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_neg_a = operand_a[WIDTH-1];
    assign w_neg_b = operand_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? (~operand_a + 1'b1) : operand_a;
    assign w_mag_b = w_neg_b ? (~operand_b + 1'b1) : operand_b;
    assign w_last  = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .i_op   (r_op),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_qm1  (r_qm1),
        .i_opnd (r_opnd),
        .o_hi   (w_hi_nx),
        .o_lo   (w_lo_nx),
        .o_qm1  (w_qm1_nx)
    );

    // Final iteration result goes straight to z_hi/z_lo, so sign fix-up works on the step output.
    always_comb begin
        w_res_hi = w_hi_nx[WIDTH-1:0];
        w_res_lo = w_lo_nx;
        if (r_op == OP_DIV) begin
            if (r_neg_q) w_res_lo = ~w_lo_nx + 1'b1;
            if (r_neg_r) w_res_hi = ~w_hi_nx[WIDTH-1:0] + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_DIV && operand_b == '0) w_next = ST_DZERO;
                    else                                 w_next = ST_RUN;
                end
            end
            ST_RUN:   if (w_last) w_next = ST_IDLE;
            ST_DZERO: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_a     <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_qm1   <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_z_hi  <= '0;
            r_z_lo  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= operand_a;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_dbz   <= 1'b0;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_qm1   <= 1'b0;
                        if (op == OP_MUL) begin
                            r_lo   <= operand_b;
                            r_opnd <= operand_a;
                        end else begin
                            r_lo   <= w_mag_a;
                            r_opnd <= w_mag_b;
                        end
                    end
                end
                ST_RUN: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_qm1 <= w_qm1_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_z_hi <= w_res_hi;
                        r_z_lo <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                ST_DZERO: begin
                    r_z_hi <= r_a;
                    r_z_lo <= '1;
                    r_dbz  <= 1'b1;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done        = r_done;
    assign z_hi        = r_z_hi;
    assign z_lo        = r_z_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized and directed checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    mul_div_unit dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .z_hi        (z_hi),
        .z_lo        (z_lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (!o) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("busy_at_e0", busy, 1);
        check("done_at_e0", done, 0);
        check("dbz_cleared_at_e0", div_by_zero, 0);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic o,
                             input logic [31:0] a, input logic [31:0] b, input bit post);
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
        int          n;
        bit          seen;
        model(o, a, b, ehi, elo, edz);
        n    = 0;
        seen = 0;
        while (n < 40 && !seen) begin
            operand_a = $urandom;
            operand_b = $urandom;
            op        = 1'($urandom);
            tick();
            n++;
            check({tag, "_busy_vs_done"}, busy, !done);
            if (done) seen = 1;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_z_hi"}, z_hi, ehi);
        check({tag, "_z_lo"}, z_lo, elo);
        check({tag, "_dbz"}, div_by_zero, edz);
        if (post) begin
            tick();
            check({tag, "_done_drop"}, done, 0);
            check({tag, "_hold_hi"}, z_hi, ehi);
            check({tag, "_hold_lo"}, z_lo, elo);
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b);
        launch(o, a, b);
        wait_done(tag, (o && b == 32'd0) ? 1 : 32, o, a, b, 1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ro;
        int          ndone;

        clear     = 1'b1;
        start     = 1'b1;
        op        = 1'b0;
        operand_a = 32'd5;
        operand_b = 32'd9;
        tick();
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_z_hi", z_hi, 0);
        check("rst_z_lo", z_lo, 0);
        check("rst_dbz", div_by_zero, 0);

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        check("mul_7_m3_const_lo", z_lo, 32'hFFFF_FFEB);
        check("mul_7_m3_const_hi", z_hi, 32'hFFFF_FFFF);
        run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000);
        check("mul_min_min_const_hi", z_hi, 32'h4000_0000);
        run_op("mul_max_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_const_lo", z_lo, 32'hFFFF_FFFD);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_100_0", 1'b1, 32'd100, 32'd0);
        run_op("mul_2_3", 1'b0, 32'd2, 32'd3);

        // Clear two cycles after unrelated stimulus, with a div-by-zero flag standing.
        run_op("div_5_0", 1'b1, 32'd5, 32'd0);
        operand_a = $urandom;
        operand_b = $urandom;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_z_hi", z_hi, 0);
        check("clr_z_lo", z_lo, 0);
        check("clr_dbz", div_by_zero, 0);

        // start during RUN must be ignored
        launch(1'b0, 32'd1234, 32'hFFFF_0001);
        repeat (9) tick();
        op        = 1'b1;
        operand_a = 32'd77;
        operand_b = 32'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", busy, 1);
        wait_done("ign", 22, 1'b0, 32'd1234, 32'hFFFF_0001, 1);

        // clear at E15 aborts with no done
        launch(1'b1, 32'd999, 32'd7);
        repeat (14) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_z_hi", z_hi, 0);
        check("abort_z_lo", z_lo, 0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // start in the done cycle is accepted
        launch(1'b0, 32'hDEAD_BEEF, 32'h0000_1235);
        wait_done("chain1", 32, 1'b0, 32'hDEAD_BEEF, 32'h0000_1235, 0);
        launch(1'b1, 32'hF000_0001, 32'd13);
        wait_done("chain2", 32, 1'b1, 32'hF000_0001, 32'd13, 1);

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
